// File: rtl/instr_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_pkg : shared types and address mapping for instr_mem_resp  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package instr_mem_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] offset;
    logic              out_of_range;
  } word_idx_t;

  // Word offset from the window base; wraps unsigned so addresses below base land out of range.
  function automatic word_idx_t word_index(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W-1:0] depth);
    word_idx_t r;
    r.offset       = (addr - base) >> 2;
    r.out_of_range = (r.offset >= depth);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_array : DEPTH_WORDS x 32 storage, 1 write + 1 sync read    |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module instr_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instr_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_resp : fixed-latency instruction memory responder with     |
// |                  flush, fault flagging and a program-load port       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module instr_mem_resp
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic [31:0] instr_addr_i,
  input  logic        flush_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic        busy_o,
  input  logic        prog_we_i,
  input  logic [31:0] prog_addr_i,
  input  logic [31:0] prog_wdata_i,
  output logic        prog_ready_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_lat_q, err_lat_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [31:0]        hold_q, hold_d;

  word_idx_t          f_widx, p_widx;
  logic               f_err;
  logic [IDX_W-1:0]   f_idx;
  logic               accept;
  logic               issue;
  logic               issue_err;
  logic [IDX_W-1:0]   issue_idx;
  logic               rd_en;
  logic               prog_we;
  logic [31:0]        arr_rdata;
  logic               unused_bits;

  assign f_widx = word_index(instr_addr_i, BASE_ADDR, ADDR_W'(DEPTH_WORDS));
  assign p_widx = word_index(prog_addr_i, BASE_ADDR, ADDR_W'(DEPTH_WORDS));
  assign f_err  = (instr_addr_i[1:0] != 2'b00) || f_widx.out_of_range;
  assign f_idx  = f_widx.offset[IDX_W-1:0];
  assign accept = fetch_enable_i && !flush_i && (state_q == ST_IDLE);

  assign unused_bits = ^{f_widx.offset[ADDR_W-1:IDX_W], p_widx.offset[ADDR_W-1:IDX_W]};

  // With no wait states the array is read straight from the live address; otherwise
  // the latched address is read on the final wait cycle.
  generate
    if (WAIT_STATES == 0) begin : g_no_wait
      logic unused_lat;
      assign issue      = accept;
      assign issue_err  = f_err;
      assign issue_idx  = f_idx;
      assign unused_lat = ^{idx_q, err_lat_q};
    end else begin : g_wait
      assign issue     = (state_q == ST_WAIT) && (cnt_q == 3'd1) && !flush_i;
      assign issue_err = err_lat_q;
      assign issue_idx = idx_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      idx_q     <= '0;
      err_lat_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_lat_q <= err_lat_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_lat_d = err_lat_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (WAIT_STATES != 0)) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
    if (accept) begin
      idx_d     = f_idx;
      err_lat_d = f_err;
    end
  end

  always_comb begin
    rvalid_d      = issue;
    err_d         = issue && issue_err;
    rd_en         = issue && !issue_err;
    busy_d        = (state_d == ST_WAIT);
    instr_rdata_o = hold_q;
    if (rvalid_q) begin
      instr_rdata_o = err_q ? 32'd0 : arr_rdata;
    end
    hold_d         = instr_rdata_o;
    instr_rvalid_o = rvalid_q;
    instr_err_o    = rvalid_q && err_q;
    busy_o         = busy_q;
    prog_ready_o   = !fetch_enable_i && (state_q == ST_IDLE);
    prog_we        = prog_we_i && prog_ready_o && (prog_addr_i[1:0] == 2'b00)
                     && !p_widx.out_of_range;
  end

  instr_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (prog_we),
    .waddr_i (p_widx.offset[IDX_W-1:0]),
    .wdata_i (prog_wdata_i),
    .re_i    (rd_en),
    .raddr_i (issue_idx),
    .rdata_o (arr_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_resp.sv
`default_nettype none
// Bench for instr_mem_resp: a zero-wait instance and a two-wait-state instance with a
// non-zero base, exercised by directed scenarios and a randomized run against a model.
`timescale 1ns/1ps
module tb_instr_mem_resp;

  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        en_a, en_b, fl_a, fl_b, we_a, we_b;
  logic [31:0] addr, paddr, pdata;
  logic [31:0] rdata_a, rdata_b;
  logic        rv_a, rv_b, err_a, err_b, busy_a, busy_b, rdy_a, rdy_b;
  logic [31:0] o_rdata;
  logic        o_rv, o_err, o_busy, o_rdy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [2][DEPTH];

  always #5 clk = ~clk;

  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_rv    = sel ? rv_b    : rv_a;
  assign o_err   = sel ? err_b   : err_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_rdy   = sel ? rdy_b   : rdy_a;

  instr_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(en_a), .instr_addr_i(addr), .flush_i(fl_a),
    .instr_rdata_o(rdata_a), .instr_rvalid_o(rv_a), .instr_err_o(err_a), .busy_o(busy_a),
    .prog_we_i(we_a), .prog_addr_i(paddr), .prog_wdata_i(pdata), .prog_ready_o(rdy_a));

  instr_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE_B)) u_ws2 (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(en_b), .instr_addr_i(addr), .flush_i(fl_b),
    .instr_rdata_o(rdata_b), .instr_rvalid_o(rv_b), .instr_err_o(err_b), .busy_o(busy_b),
    .prog_we_i(we_b), .prog_addr_i(paddr), .prog_wdata_i(pdata), .prog_ready_o(rdy_b));

  task automatic drive(input logic en, input logic [31:0] a, input logic fl,
                       input logic we, input logic [31:0] pa, input logic [31:0] pd);
    en_a = en && !sel;  en_b = en && sel;
    fl_a = fl && !sel;  fl_b = fl && sel;
    we_a = we && !sel;  we_b = we && sel;
    addr = a; paddr = pa; pdata = pd;
  endtask

  function automatic logic [31:0] base_of(input logic s);
    return s ? BASE_B : 32'h0;
  endfunction

  function automatic logic [31:0] pick_addr(input logic [31:0] base);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return base + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (r == 6) return base + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    else if (r == 7) return base + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 31));
    else if (r == 8) return base - 32'd4;
    else             return $urandom;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_checks++;
      if ({o_rv, o_err, o_busy} !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags dut%0d: got rv/err/busy=%b want 000", s, {o_rv, o_err, o_busy});
      end
      n_checks++;
      if (o_rdata !== 32'd0) begin
        n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 0", s, o_rdata);
      end
      n_checks++;
      if (o_rdy !== 1'b1) begin
        n_fail++; $display("FAIL reset_prog_ready dut%0d: got %b want 1", s, o_rdy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_prog_load();
    logic [31:0] d;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < DEPTH; i++) begin
        d = (i < 4) ? 32'(32'h11 * (i + 1)) : $urandom;
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b1, base_of(sel) + 32'(4 * i), d);
        #1;
        n_checks++;
        if (o_rdy !== 1'b1) begin
          n_fail++; $display("FAIL prog_load_ready dut%0d word %0d: got %b want 1", s, i, o_rdy);
        end
        mem_m[s][i] = d;
      end
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_ws0_stream();
    sel = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0) begin
        n_fail++; $display("FAIL ws0_busy cycle %0d: got %b want 0", i, o_busy);
      end
      if (i > 0) begin
        n_checks++;
        if (o_rv !== 1'b1 || o_rdata !== 32'(32'h11 * i)) begin
          n_fail++; $display("FAIL ws0_stream resp %0d: got rv=%b data=%h want rv=1 data=%h", i, o_rv, o_rdata, 32'(32'h11 * i));
        end
      end
      drive(i < 4, 32'(4 * i), 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(negedge clk);
    n_checks++;
    if (o_rv !== 1'b0 || o_rdata !== 32'h44) begin
      n_fail++; $display("FAIL ws0_hold: got rv=%b data=%h want rv=0 data=00000044", o_rv, o_rdata);
    end
  endtask

  task automatic test_ws2_timing();
    bit busy_t[6] = '{1, 1, 0, 1, 1, 0};
    bit rv_t[6]   = '{0, 0, 1, 0, 0, 1};
    sel = 1'b1;
    @(negedge clk);
    drive(1'b1, BASE_B, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_busy !== busy_t[k-1] || o_rv !== rv_t[k-1]) begin
        n_fail++; $display("FAIL ws2_timing T+%0d: got busy=%b rv=%b want busy=%b rv=%b", k, o_busy, o_rv, busy_t[k-1], rv_t[k-1]);
      end
      if (k == 3 || k == 6) begin
        n_checks++;
        if (o_rdata !== ((k == 3) ? 32'h11 : 32'h22) || o_err !== 1'b0) begin
          n_fail++; $display("FAIL ws2_data T+%0d: got data=%h err=%b want data=%h err=0", k, o_rdata, o_err, (k == 3) ? 32'h11 : 32'h22);
        end
      end
      drive(k < 6, BASE_B + 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(negedge clk);
    n_checks++;
    if (o_rv !== 1'b0) begin
      n_fail++; $display("FAIL ws2_idle: got rv=%b want 0", o_rv);
    end
  endtask

  task automatic test_faults();
    logic [31:0] a_t[3] = '{32'h2, 32'h40, 32'h0};
    bit          e_t[3] = '{1, 1, 0};
    logic [31:0] d_t[3] = '{32'h0, 32'h0, 32'h11};
    sel = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (o_rv !== 1'b1 || o_err !== e_t[i-1] || o_rdata !== d_t[i-1]) begin
          n_fail++; $display("FAIL fault addr %h: got rv=%b err=%b data=%h want rv=1 err=%b data=%h", a_t[i-1], o_rv, o_err, o_rdata, e_t[i-1], d_t[i-1]);
        end
      end
      if (i < 3) drive(1'b1, a_t[i], 1'b0, 1'b0, 32'd0, 32'd0);
      else       drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(negedge clk);
    n_checks++;
    if (o_rv !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h11) begin
      n_fail++; $display("FAIL fault_hold: got rv=%b err=%b data=%h want 0 0 00000011", o_rv, o_err, o_rdata);
    end
  endtask

  task automatic test_flush();
    sel = 1'b1;
    @(negedge clk);
    drive(1'b1, BASE_B + 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_busy: got %b want 1", o_busy);
    end
    drive(1'b1, BASE_B + 32'd8, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_rv !== 1'b0) begin
      n_fail++; $display("FAIL flush_T+2: got busy=%b rv=%b want 0 0", o_busy, o_rv);
    end
    drive(1'b1, BASE_B + 32'd8, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_rv !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++; $display("FAIL flush_T+%0d: got rv=%b busy=%b want rv=0 busy=1", k, o_rv, o_busy);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(negedge clk);
    n_checks++;
    if (o_rv !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'h33 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_refetch: got rv=%b err=%b data=%h busy=%b want 1 0 00000033 0", o_rv, o_err, o_rdata, o_busy);
    end
  endtask

  task automatic test_prog_gating();
    sel = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (o_rdy !== 1'b0) begin
      n_fail++; $display("FAIL gating_ready_busy_fetch: got %b want 0", o_rdy);
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h1, 32'hBAD0_0001);
    #1;
    n_checks++;
    if (o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL gating_ready_idle: got %b want 1", o_rdy);
    end
    @(negedge clk);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++;
    if (o_rv !== 1'b1 || o_rdata !== 32'h33) begin
      n_fail++; $display("FAIL gating_word2: got rv=%b data=%h want 1 00000033", o_rv, o_rdata);
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++;
    if (o_rv !== 1'b1 || o_rdata !== 32'h11) begin
      n_fail++; $display("FAIL gating_misaligned_drop: got rv=%b data=%h want 1 00000011", o_rv, o_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    sel = 1'b1;
    @(negedge clk);
    drive(1'b1, BASE_B, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_busy: got %b want 1", o_busy);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_rv, o_err, o_busy} !== 3'b000 || o_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_wait_outputs: got rv/err/busy=%b data=%h want 000 0", {o_rv, o_err, o_busy}, o_rdata);
    end
    rst = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_rv !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_wait_T+%0d: got rv=%b busy=%b want 0 0", k, o_rv, o_busy);
      end
    end
  endtask

  // The model schedules each accepted fetch for delivery N+1 cycles later; flush cancels it.
  task automatic test_random(input int s, input int cycles);
    int          n_ws;
    logic [31:0] base, last, a, pa, pd, off, poff, pdat;
    bit          pv, perr, en, fl, we, exp_rv, exp_rdy;
    int          pc;
    n_ws = (s != 0) ? 2 : 0;
    base = base_of(s[0]);
    pv = 1'b0; perr = 1'b0; pc = 0; pdat = 32'd0; last = 32'd0;
    sel = s[0];
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      exp_rv = pv && (pc == c);
      if (exp_rv) begin
        last = perr ? 32'd0 : pdat;
        pv   = 1'b0;
      end
      n_checks++;
      if (o_rv !== exp_rv || o_err !== (exp_rv && perr)) begin
        n_fail++; $display("FAIL rand%0d cyc %0d rv/err: got %b/%b want %b/%b", s, c, o_rv, o_err, exp_rv, exp_rv && perr);
      end
      n_checks++;
      if (o_rdata !== last) begin
        n_fail++; $display("FAIL rand%0d cyc %0d rdata: got %h want %h", s, c, o_rdata, last);
      end
      n_checks++;
      if (o_busy !== pv) begin
        n_fail++; $display("FAIL rand%0d cyc %0d busy: got %b want %b", s, c, o_busy, pv);
      end
      en = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 9) == 0);
      we = ($urandom_range(0, 1) == 1);
      a  = pick_addr(base);
      pa = pick_addr(base);
      pd = $urandom;
      drive(en, a, fl, we, pa, pd);
      #1;
      exp_rdy = !en && !pv;
      n_checks++;
      if (o_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rand%0d cyc %0d prog_ready: got %b want %b", s, c, o_rdy, exp_rdy);
      end
      poff = (pa - base) >> 2;
      if (we && exp_rdy && pa[1:0] == 2'b00 && poff < DEPTH) mem_m[s][poff[3:0]] = pd;
      if (fl) begin
        pv = 1'b0;
      end else if (en && !pv) begin
        off  = (a - base) >> 2;
        perr = (a[1:0] != 2'b00) || (off >= DEPTH);
        pdat = perr ? 32'd0 : mem_m[s][off[3:0]];
        pv   = 1'b1;
        pc   = c + n_ws + 1;
      end
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_prog_load();
    test_ws0_stream();
    test_ws2_timing();
    test_faults();
    test_flush();
    test_prog_gating();
    test_reset_in_wait();
    test_random(0, 400);
    test_random(1, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
